// File: rtl/dual_core_mem_arbiter_if.sv
// Request/response bundle between the per-core request logic, the arbiter and the RAM.
interface dual_core_mem_arbiter_if #(
   parameter int unsigned CORES = 2
);
   // Core request side
   logic [CORES-1:0]         iREN;
   logic [CORES-1:0][31:0]   iaddr;
   logic [CORES-1:0]         dREN;
   logic [CORES-1:0]         dWEN;
   logic [CORES-1:0][31:0]   daddr;
   logic [CORES-1:0][31:0]   dstore;
   logic [CORES-1:0]         iwait;
   logic [CORES-1:0]         dwait;
   logic [31:0]              iload;
   logic [31:0]              dload;
   // RAM side
   logic                     ramREN;
   logic                     ramWEN;
   logic [31:0]              ramaddr;
   logic [31:0]              ramstore;
   logic [31:0]              ramload;
   logic                     ram_ready;
   logic                     timeout;

   // Requesters and RAM model
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
   );

   // Arbiter
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
   );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// Shares one RAM port among the instruction and data streams of two cores:
// round-robin between cores, data before instruction within a core, with a
// watchdog that aborts stalled RAM accesses.
module dual_core_mem_arbiter #(
   parameter int unsigned CORES        = 2,
   parameter int unsigned MAX_WAIT     = 64,
   parameter logic [31:0] TIMEOUT_WORD = 32'hBAD1_BAD1
) (
   input logic                    CLK,
   input logic                    RST,
   dual_core_mem_arbiter_if.slave bus
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned WD_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state;
   logic              rr;
   logic [WD_W-1:0]   wd;
   logic              cap_core;
   logic              cap_data;
   logic              cap_wr;

   logic [CORES-1:0]  has_req;
   logic              sel_core;
   logic              sel_data;
   logic              sel_wr;
   logic [WORD_W-1:0] sel_addr;
   logic [WORD_W-1:0] sel_store;

   // Pick the requester to capture: rr core first, then the other; data beats fetch, write beats read
   always_comb begin
      has_req   = bus.iREN | bus.dREN | bus.dWEN;
      sel_core  = rr;
      if (!has_req[rr]) begin
         sel_core = ~rr;
      end
      sel_data  = bus.dREN[sel_core] | bus.dWEN[sel_core];
      sel_wr    = bus.dWEN[sel_core];
      sel_addr  = sel_data ? bus.daddr[sel_core] : bus.iaddr[sel_core];
      sel_store = sel_wr ? bus.dstore[sel_core] : '0;
   end

   // IDLE/ACCESS/RESP sequencer; RAM address/store registers double as the captured operands
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         rr           <= 1'b0;
         wd           <= '0;
         cap_core     <= 1'b0;
         cap_data     <= 1'b0;
         cap_wr       <= 1'b0;
         bus.iwait    <= '1;
         bus.dwait    <= '1;
         bus.iload    <= '0;
         bus.dload    <= '0;
         bus.ramREN   <= 1'b0;
         bus.ramWEN   <= 1'b0;
         bus.ramaddr  <= '0;
         bus.ramstore <= '0;
         bus.timeout  <= 1'b0;
      end else begin
         bus.iwait   <= '1;
         bus.dwait   <= '1;
         bus.timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|has_req) begin
                  cap_core     <= sel_core;
                  cap_data     <= sel_data;
                  cap_wr       <= sel_wr;
                  bus.ramaddr  <= sel_addr;
                  bus.ramstore <= sel_store;
                  bus.ramREN   <= ~sel_wr;
                  bus.ramWEN   <= sel_wr;
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               wd <= wd + WD_W'(1);
               // ram_ready has priority over the watchdog expiring in the same cycle
               if (bus.ram_ready || (wd == WD_LAST)) begin
                  state      <= RESP;
                  bus.ramREN <= 1'b0;
                  bus.ramWEN <= 1'b0;
                  if (cap_data) begin
                     bus.dwait[cap_core] <= 1'b0;
                  end else begin
                     bus.iwait[cap_core] <= 1'b0;
                  end
                  if (!bus.ram_ready) begin
                     bus.timeout <= 1'b1;
                     if (cap_data) begin
                        bus.dload <= TIMEOUT_WORD;
                     end else begin
                        bus.iload <= TIMEOUT_WORD;
                     end
                  end else if (!cap_wr) begin
                     if (cap_data) begin
                        bus.dload <= bus.ramload;
                     end else begin
                        bus.iload <= bus.ramload;
                     end
                  end
               end
            end
            RESP: begin
               rr    <= ~cap_core;
               wd    <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
